// File: rtl/fir_video_pkg.sv
// Shared constants, state encoding and saturating-counter helpers for the
// post-FIR video border mask.
package fir_video_pkg;

   localparam int H_ACTIVE_DEF = 1280;
   localparam int V_ACTIVE_DEF = 720;
   localparam int BORDER_DEF   = 2;
   localparam int PIX_W        = 8;
   localparam int X_W          = 11;
   localparam int Y_W          = 10;

   typedef enum logic {
      IDLE  = 1'b0,
      FRAME = 1'b1
   } state_t;

   function automatic logic [X_W-1:0] sat_inc_x(input logic [X_W-1:0] v);
      return (&v) ? v : v + X_W'(1);
   endfunction

   function automatic logic [Y_W-1:0] sat_inc_y(input logic [Y_W-1:0] v);
      return (&v) ? v : v + Y_W'(1);
   endfunction

endpackage

// File: rtl/fir_border_mask_if.sv
// Pixel bus with its sync strobes; master drives, slave receives.
interface fir_border_mask_if;
   import fir_video_pkg::*;

   logic [PIX_W-1:0] r;
   logic [PIX_W-1:0] g;
   logic [PIX_W-1:0] b;
   logic             dv;
   logic             hs;
   logic             vs;

   modport master (output r, g, b, dv, hs, vs);
   modport slave  (input  r, g, b, dv, hs, vs);

endinterface

// File: rtl/sync_edge_det.sv
// Keeps a one-cycle delayed copy of a strobe and flags its edges against
// the current sample, so edges are usable in the same cycle they arrive.
module sync_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic sig,
   output logic rise,
   output logic fall
);

   logic sig_d;

   always_ff @(posedge clk) begin
      if (!rst) sig_d <= 1'b0;
      else      sig_d <= sig;
   end

   assign rise = sig & ~sig_d;
   assign fall = ~sig & sig_d;

endmodule

// File: rtl/fir_border_mask.sv
// Replaces pixels in the invalid 5x5-window margin with a constant, tracks
// pixel position and flags malformed lines; one clock of latency throughout.
//
// state | meaning
// IDLE  | no frame start seen since reset; every pixel masked when enabled
// FRAME | inside a frame; position counters valid
module fir_border_mask
   import fir_video_pkg::*;
#(
   parameter int               H_ACTIVE   = H_ACTIVE_DEF,
   parameter int               V_ACTIVE   = V_ACTIVE_DEF,
   parameter int               BORDER     = BORDER_DEF,
   parameter logic [PIX_W-1:0] BORDER_VAL = 8'h00
) (
   input  logic               clk,
   input  logic               rst,
   fir_border_mask_if.slave   vid_in,
   fir_border_mask_if.master  vid_out,
   input  logic               mask_en,
   output logic [X_W-1:0]     x_index,
   output logic [Y_W-1:0]     y_index,
   output logic               frame_done,
   output logic               line_err
);

   state_t         state;
   state_t         state_nxt;
   logic [X_W-1:0] x_cnt;
   logic [Y_W-1:0] y_cnt;
   logic [X_W-1:0] x_cur;
   logic [Y_W-1:0] y_cur;
   logic           hs_rise, vs_rise, dv_fall;
   logic           hs_fall_unused, vs_fall_unused, dv_rise_unused;
   logic           masked;
   logic           line_bad;

   sync_edge_det u_hs_edge (.clk(clk), .rst(rst), .sig(vid_in.hs), .rise(hs_rise),        .fall(hs_fall_unused));
   sync_edge_det u_vs_edge (.clk(clk), .rst(rst), .sig(vid_in.vs), .rise(vs_rise),        .fall(vs_fall_unused));
   sync_edge_det u_dv_edge (.clk(clk), .rst(rst), .sig(vid_in.dv), .rise(dv_rise_unused), .fall(dv_fall));

   // Position of the pixel presented this cycle: a clearing edge makes it pixel 0.
   always_comb begin
      x_cur     = (vs_rise || hs_rise) ? '0 : x_cnt;
      y_cur     = vs_rise ? '0 : y_cnt;
      state_nxt = vs_rise ? FRAME : state;
      masked    = mask_en && ((state_nxt == IDLE)
                              || (int'(x_cur) <  BORDER)
                              || (int'(x_cur) >= H_ACTIVE - BORDER)
                              || (int'(y_cur) <  BORDER)
                              || (int'(y_cur) >= V_ACTIVE - BORDER));
      // x_cnt still holds the completed line's pixel count on the dv fall
      line_bad  = dv_fall && (state == FRAME) && (int'(x_cnt) != H_ACTIVE);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= IDLE;
         x_cnt       <= '0;
         y_cnt       <= '0;
         vid_out.r   <= '0;
         vid_out.g   <= '0;
         vid_out.b   <= '0;
         vid_out.dv  <= 1'b0;
         vid_out.hs  <= 1'b0;
         vid_out.vs  <= 1'b0;
         x_index     <= '0;
         y_index     <= '0;
         frame_done  <= 1'b0;
         line_err    <= 1'b0;
      end else begin
         state      <= state_nxt;
         x_cnt      <= vid_in.dv ? sat_inc_x(x_cur) : x_cur;
         if (vs_rise)      y_cnt <= '0;
         else if (dv_fall) y_cnt <= sat_inc_y(y_cnt);

         vid_out.r  <= masked ? BORDER_VAL : vid_in.r;
         vid_out.g  <= masked ? BORDER_VAL : vid_in.g;
         vid_out.b  <= masked ? BORDER_VAL : vid_in.b;
         vid_out.dv <= vid_in.dv;
         vid_out.hs <= vid_in.hs;
         vid_out.vs <= vid_in.vs;
         x_index    <= x_cur;
         y_index    <= y_cur;
         frame_done <= vs_rise && (state == FRAME);

         if (line_bad)     line_err <= 1'b1;
         else if (vs_rise) line_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fir_border_mask.sv
// Directed bench for fir_border_mask with an 8x6 active area and 2-pixel border.
module tb_fir_border_mask;
   import fir_video_pkg::*;

   localparam int H = 8;
   localparam int V = 6;
   localparam int B = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        mask_en = 1'b1;
   logic [10:0] x_index;
   logic [9:0]  y_index;
   logic        frame_done;
   logic        line_err;

   int pass_cnt  = 0;
   int total_cnt = 0;
   bit in_frame  = 1'b0;
   bit err_model = 1'b0;

   fir_border_mask_if vin ();
   fir_border_mask_if vout ();

   fir_border_mask #(.H_ACTIVE(H), .V_ACTIVE(V), .BORDER(B), .BORDER_VAL(8'h00)) dut (
      .clk(clk), .rst(rst), .vid_in(vin), .vid_out(vout), .mask_en(mask_en),
      .x_index(x_index), .y_index(y_index), .frame_done(frame_done), .line_err(line_err)
   );

   always #5 clk = ~clk;

   task automatic drive(input logic vs, input logic hs, input logic dv,
                        input logic [7:0] rv, input logic [7:0] gv, input logic [7:0] bv);
      vin.vs = vs; vin.hs = hs; vin.dv = dv;
      vin.r = rv; vin.g = gv; vin.b = bv;
      @(posedge clk); #1;
   endtask

   function automatic bit exp_masked(input int x, input int y);
      return mask_en && (!in_frame || x < B || x >= H - B || y < B || y >= V - B);
   endfunction

   task automatic do_vs();
      logic exp_fd;
      exp_fd = in_frame;
      drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      in_frame = 1'b1; err_model = 1'b0;
      total_cnt++;
      if ({vout.vs, frame_done, line_err} !== {1'b1, exp_fd, 1'b0})
         $display("FAIL vs_edge got vs/fd/err=%b%b%b exp=%b%b%b", vout.vs, frame_done, line_err, 1'b1, exp_fd, 1'b0);
      else pass_cnt++;
      drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      total_cnt++;
      if ({vout.vs, frame_done} !== 2'b00)
         $display("FAIL vs_after got vs/fd=%b%b exp=00", vout.vs, frame_done);
      else pass_cnt++;
   endtask

   task automatic do_line(input int y, input int npix,
                          input logic [7:0] rv, input logic [7:0] gv, input logic [7:0] bv);
      logic [46:0] got, exp;
      drive(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
      total_cnt++;
      if ({vout.hs, vout.dv} !== 2'b10)
         $display("FAIL hs_line got hs/dv=%b%b exp=10", vout.hs, vout.dv);
      else pass_cnt++;
      drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      for (int x = 0; x < npix; x++) begin
         drive(1'b0, 1'b0, 1'b1, rv, gv, bv);
         got = {vout.dv, x_index, y_index, vout.r, vout.g, vout.b};
         exp = {1'b1, 11'(x), 10'(y), exp_masked(x, y) ? 24'h000000 : {rv, gv, bv}};
         total_cnt++;
         if (got !== exp) $display("FAIL pixel x=%0d y=%0d got=%h exp=%h", x, y, got, exp);
         else pass_cnt++;
      end
      drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      if (in_frame && npix != H) err_model = 1'b1;
      total_cnt++;
      if ({vout.dv, line_err} !== {1'b0, err_model})
         $display("FAIL line_end y=%0d got dv/err=%b%b exp=0%b", y, vout.dv, line_err, err_model);
      else pass_cnt++;
      drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      drive(1'b1, 1'b1, 1'b1, 8'hAA, 8'hAA, 8'hAA);
      drive(1'b1, 1'b1, 1'b1, 8'hAA, 8'hAA, 8'hAA);
      total_cnt++;
      if ({vout.r, vout.g, vout.b, vout.dv, vout.hs, vout.vs, x_index, y_index, frame_done, line_err} !== '0)
         $display("FAIL reset_state got r=%h g=%h b=%h dv=%b hs=%b vs=%b x=%0d y=%0d fd=%b err=%b exp all 0",
                  vout.r, vout.g, vout.b, vout.dv, vout.hs, vout.vs, x_index, y_index, frame_done, line_err);
      else pass_cnt++;
      drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      rst = 1'b1;
      in_frame = 1'b0; err_model = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
   endtask

   task automatic test_idle_mask();
      mask_en = 1'b1;
      drive(1'b0, 1'b0, 1'b1, 8'hAA, 8'hAA, 8'hAA);
      total_cnt++;
      if ({vout.dv, vout.r, x_index} !== {1'b1, 8'h00, 11'd0})
         $display("FAIL idle_mask got dv=%b r=%h x=%0d exp dv=1 r=00 x=0", vout.dv, vout.r, x_index);
      else pass_cnt++;
      mask_en = 1'b0;
      drive(1'b0, 1'b0, 1'b1, 8'hAA, 8'hAA, 8'hAA);
      total_cnt++;
      if ({vout.dv, vout.r, x_index} !== {1'b1, 8'hAA, 11'd1})
         $display("FAIL idle_pass got dv=%b r=%h x=%0d exp dv=1 r=aa x=1", vout.dv, vout.r, x_index);
      else pass_cnt++;
      drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      total_cnt++;
      if (line_err !== 1'b0) $display("FAIL idle_no_err got=%b exp=0", line_err);
      else pass_cnt++;
      mask_en = 1'b1;
   endtask

   task automatic test_mask_frame();
      mask_en = 1'b1;
      for (int f = 0; f < 2; f++) begin
         do_vs();
         for (int y = 0; y < V; y++) do_line(y, H, 8'hAA, 8'hAA, 8'hAA);
      end
   endtask

   task automatic test_passthrough();
      mask_en = 1'b0;
      do_vs();
      for (int y = 0; y < V; y++) do_line(y, H, 8'hAA, 8'hAA, 8'hAA);
      mask_en = 1'b1;
   endtask

   task automatic test_channels();
      do_vs();
      for (int y = 0; y < V; y++) do_line(y, H, 8'h11, 8'h22, 8'h33);
   endtask

   task automatic test_line_err();
      do_vs();
      for (int y = 0; y < V; y++) do_line(y, (y == 2) ? H - 1 : H, 8'hAA, 8'hAA, 8'hAA);
      do_vs();
      do_line(0, H, 8'hAA, 8'hAA, 8'hAA);
   endtask

   task automatic test_vs_hs_together();
      drive(1'b1, 1'b1, 1'b1, 8'hAA, 8'hAA, 8'hAA);
      in_frame = 1'b1; err_model = 1'b0;
      total_cnt++;
      if ({x_index, y_index, vout.vs, vout.hs, vout.dv, frame_done, vout.r} !== {11'd0, 10'd0, 4'b1111, 8'h00})
         $display("FAIL vs_hs_same got x=%0d y=%0d vs/hs/dv/fd=%b%b%b%b r=%h exp x=0 y=0 1111 r=00",
                  x_index, y_index, vout.vs, vout.hs, vout.dv, frame_done, vout.r);
      else pass_cnt++;
      for (int x = 1; x < 3; x++) begin
         drive(1'b0, 1'b0, 1'b1, 8'hAA, 8'hAA, 8'hAA);
         total_cnt++;
         if ({x_index, y_index, frame_done} !== {11'(x), 10'd0, 1'b0})
            $display("FAIL vs_hs_next got x=%0d y=%0d fd=%b exp x=%0d y=0 fd=0", x_index, y_index, frame_done, x);
         else pass_cnt++;
      end
      drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      err_model = 1'b1;
      total_cnt++;
      if (line_err !== 1'b1) $display("FAIL short_err got=%b exp=1", line_err);
      else pass_cnt++;
      drive(1'b0, 1'b1, 1'b1, 8'hAA, 8'hAA, 8'hAA);
      total_cnt++;
      if ({x_index, y_index} !== {11'd0, 10'd1})
         $display("FAIL hs_dv_same got x=%0d y=%0d exp x=0 y=1", x_index, y_index);
      else pass_cnt++;
      drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
   endtask

   task automatic test_saturation();
      do_vs();
      drive(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
      drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      for (int i = 0; i < 3000; i++) begin
         drive(1'b0, 1'b0, 1'b1, 8'hAA, 8'hAA, 8'hAA);
         if (i == 0 || i == 2046 || i == 2047 || i == 2999) begin
            total_cnt++;
            if (x_index !== 11'((i > 2047) ? 2047 : i))
               $display("FAIL x_sat i=%0d got x=%0d exp=%0d", i, x_index, (i > 2047) ? 2047 : i);
            else pass_cnt++;
         end
      end
      drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      err_model = 1'b1;
      total_cnt++;
      if (line_err !== 1'b1) $display("FAIL sat_err got=%b exp=1", line_err);
      else pass_cnt++;
      drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
   endtask

   task automatic test_reset_mid();
      logic [29:0] got, exp;
      do_vs();
      for (int y = 0; y < 3; y++) do_line(y, H, 8'hAA, 8'hAA, 8'hAA);
      drive(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
      drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      for (int x = 0; x < 4; x++) begin
         drive(1'b0, 1'b0, 1'b1, 8'hAA, 8'hAA, 8'hAA);
         got = {x_index, y_index, vout.r, vout.dv};
         exp = {11'(x), 10'd3, exp_masked(x, 3) ? 8'h00 : 8'hAA, 1'b1};
         total_cnt++;
         if (got !== exp) $display("FAIL pre_reset x=%0d got=%h exp=%h", x, got, exp);
         else pass_cnt++;
      end
      rst = 1'b0;
      drive(1'b0, 1'b0, 1'b1, 8'hAA, 8'hAA, 8'hAA);
      rst = 1'b1;
      in_frame = 1'b0; err_model = 1'b0;
      total_cnt++;
      if ({vout.r, vout.g, vout.b, vout.dv, vout.hs, vout.vs, x_index, y_index, frame_done, line_err} !== '0)
         $display("FAIL mid_reset got r=%h dv=%b x=%0d y=%0d err=%b exp all 0", vout.r, vout.dv, x_index, y_index, line_err);
      else pass_cnt++;
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 1'b0, 1'b1, 8'hAA, 8'hAA, 8'hAA);
         got = {x_index, y_index, vout.r, vout.dv};
         exp = {11'(k), 10'd0, 8'h00, 1'b1};
         total_cnt++;
         if (got !== exp) $display("FAIL post_reset k=%0d got=%h exp=%h", k, got, exp);
         else pass_cnt++;
      end
      drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      total_cnt++;
      if (line_err !== 1'b0) $display("FAIL post_reset_err got=%b exp=0", line_err);
      else pass_cnt++;
      drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      do_line(1, H, 8'hAA, 8'hAA, 8'hAA);
      do_line(2, H, 8'hAA, 8'hAA, 8'hAA);
      do_vs();
      for (int y = 0; y < V; y++) do_line(y, H, 8'hAA, 8'hAA, 8'hAA);
   endtask

   initial begin
      vin.r = 8'h00; vin.g = 8'h00; vin.b = 8'h00;
      vin.dv = 1'b0; vin.hs = 1'b0; vin.vs = 1'b0;
      test_reset();
      test_idle_mask();
      test_mask_frame();
      test_passthrough();
      test_channels();
      test_line_err();
      test_vs_hs_together();
      test_saturation();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
